// File: rtl/signal_switch_nto1.sv
// -----------------------------------------------------------------------------
// signal_switch_nto1
//
// Registered N-to-1 signal switch with a valid/ready channel-select handshake
// and break-before-make blanking. On a channel change, OUT is forced to zero
// and OUT_VALID is held low while the switch moves. A consumer therefore never
// sees a word that mixes data from two sources.
//
// Parameters
//   N_CH        number of input channels (>= 2, any value)
//   WIDTH       data bits per channel
//   DEAD_CYCLES cycles SEL_READY stays low on a channel change (0 = no blanking)
//   RST_CH      channel connected after reset
//
// Ports
//   CLK        clock; all logic runs on the rising edge
//   RST        synchronous active-high reset; it overrides everything else
//   IN_DATA    packed channels; channel k is IN_DATA[k*WIDTH +: WIDTH]
//   SEL_REQ    requested channel
//   SEL_VALID  request valid
//   SEL_READY  high when a request can be accepted (state is ACTIVE)
//   OUT        registered output data
//   OUT_VALID  high when OUT carries the data of the current channel
//   CUR_SEL    channel currently connected
//   SEL_ERR    one-cycle pulse after an out-of-range request is rejected
// -----------------------------------------------------------------------------
module signal_switch_nto1 #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 8,
    parameter int DEAD_CYCLES = 2,
    parameter int RST_CH      = 0,
    localparam int SEL_W      = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_CH*WIDTH-1:0]   IN_DATA,
    input  logic [SEL_W-1:0]        SEL_REQ,
    input  logic                    SEL_VALID,
    output logic                    SEL_READY,
    output logic [WIDTH-1:0]        OUT,
    output logic                    OUT_VALID,
    output logic [SEL_W-1:0]        CUR_SEL,
    output logic                    SEL_ERR
);

    // The counter holds DEAD_CYCLES-1 at most.
    localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEAD_LOAD =
        CNT_W'((DEAD_CYCLES > 0) ? (DEAD_CYCLES - 1) : 0);
    localparam logic             NO_DEAD   = (DEAD_CYCLES == 0);
    // Use one extra bit so the range compare still works when N_CH == 2**SEL_W.
    localparam logic [SEL_W:0]   N_CH_L    = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] RST_SEL   = SEL_W'(RST_CH);

    typedef enum logic [0:0] {
        ST_ACTIVE = 1'b0,
        ST_BREAK  = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [SEL_W-1:0]   pend_r, pend_s;
    logic [SEL_W-1:0]   cur_sel_r, cur_sel_s;
    logic [WIDTH-1:0]   out_r, out_s;
    logic               out_valid_r, out_valid_s;
    logic               sel_err_r, sel_err_s;
    logic [WIDTH-1:0]   sel_data_s;
    logic               req_oor_s;

    // AND-OR mux of the connected channel. This form is safe for any N_CH,
    // including values that are not a power of 2.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            sel_data_s = sel_data_s |
                (IN_DATA[k*WIDTH +: WIDTH] & {WIDTH{cur_sel_r == SEL_W'(k)}});
        end
    end

    // A requested code beyond the last channel is out of range.
    always_comb begin
        req_oor_s = ({1'b0, SEL_REQ} >= N_CH_L);
    end

    // Next-state and next-output logic of the ACTIVE/BREAK controller.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pend_s      = pend_r;
        cur_sel_s   = cur_sel_r;
        out_s       = sel_data_s;
        out_valid_s = 1'b1;
        sel_err_s   = 1'b0;
        case (state_r)
            ST_ACTIVE: begin
                if (SEL_VALID) begin
                    if (req_oor_s) begin
                        // Reject the request. The data path keeps running.
                        sel_err_s = 1'b1;
                    end else if (SEL_REQ == cur_sel_r) begin
                        // Request for the current channel: nothing to do.
                        sel_err_s = 1'b0;
                    end else if (NO_DEAD) begin
                        cur_sel_s = SEL_REQ;
                    end else begin
                        // Break before make: blank the output at the accept
                        // edge and change channel only when the count expires.
                        pend_s      = SEL_REQ;
                        cnt_s       = DEAD_LOAD;
                        state_s     = ST_BREAK;
                        out_s       = {WIDTH{1'b0}};
                        out_valid_s = 1'b0;
                    end
                end else begin
                    sel_err_s = 1'b0;
                end
            end
            ST_BREAK: begin
                // Blank on every BREAK edge, including the one that changes
                // channel. New data therefore appears one edge after READY
                // returns.
                out_s       = {WIDTH{1'b0}};
                out_valid_s = 1'b0;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    cur_sel_s = pend_r;
                    state_s   = ST_ACTIVE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s     = ST_ACTIVE;
                out_s       = {WIDTH{1'b0}};
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_ACTIVE;
            cnt_r       <= {CNT_W{1'b0}};
            pend_r      <= RST_SEL;
            cur_sel_r   <= RST_SEL;
            out_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            sel_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pend_r      <= pend_s;
            cur_sel_r   <= cur_sel_s;
            out_r       <= out_s;
            out_valid_r <= out_valid_s;
            sel_err_r   <= sel_err_s;
        end
    end

    assign SEL_READY = (state_r == ST_ACTIVE);
    assign OUT       = out_r;
    assign OUT_VALID = out_valid_r;
    assign CUR_SEL   = cur_sel_r;
    assign SEL_ERR   = sel_err_r;

endmodule

// File: tb/tb_signal_switch_nto1.sv
// -----------------------------------------------------------------------------
// Testbench for signal_switch_nto1.
// It uses three instances:
//   A: N_CH=4, DEAD_CYCLES=2, driven by a table of per-cycle vectors
//   B: N_CH=3, DEAD_CYCLES=2, checks rejection of an out-of-range request
//   C: N_CH=4, DEAD_CYCLES=0, sweeps every (current, requested) channel pair
//      with random data
// -----------------------------------------------------------------------------
module tb_signal_switch_nto1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance A ----------------
    logic [31:0] a_in;
    logic [1:0]  a_req;
    logic        a_vld;
    logic        a_rdy;
    logic [7:0]  a_out;
    logic        a_ovld;
    logic [1:0]  a_cur;
    logic        a_err;

    signal_switch_nto1 #(.N_CH(4), .WIDTH(8), .DEAD_CYCLES(2), .RST_CH(0)) dut_a (
        .CLK(clk), .RST(rst), .IN_DATA(a_in), .SEL_REQ(a_req), .SEL_VALID(a_vld),
        .SEL_READY(a_rdy), .OUT(a_out), .OUT_VALID(a_ovld), .CUR_SEL(a_cur),
        .SEL_ERR(a_err)
    );

    // ---------------- instance B ----------------
    logic [23:0] b_in;
    logic [1:0]  b_req;
    logic        b_vld;
    logic        b_rdy;
    logic [7:0]  b_out;
    logic        b_ovld;
    logic [1:0]  b_cur;
    logic        b_err;

    signal_switch_nto1 #(.N_CH(3), .WIDTH(8), .DEAD_CYCLES(2), .RST_CH(0)) dut_b (
        .CLK(clk), .RST(rst), .IN_DATA(b_in), .SEL_REQ(b_req), .SEL_VALID(b_vld),
        .SEL_READY(b_rdy), .OUT(b_out), .OUT_VALID(b_ovld), .CUR_SEL(b_cur),
        .SEL_ERR(b_err)
    );

    // ---------------- instance C ----------------
    logic [31:0] c_in;
    logic [1:0]  c_req;
    logic        c_vld;
    logic        c_rdy;
    logic [7:0]  c_out;
    logic        c_ovld;
    logic [1:0]  c_cur;
    logic        c_err;

    signal_switch_nto1 #(.N_CH(4), .WIDTH(8), .DEAD_CYCLES(0), .RST_CH(0)) dut_c (
        .CLK(clk), .RST(rst), .IN_DATA(c_in), .SEL_REQ(c_req), .SEL_VALID(c_vld),
        .SEL_READY(c_rdy), .OUT(c_out), .OUT_VALID(c_ovld), .CUR_SEL(c_cur),
        .SEL_ERR(c_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] din;
        logic [1:0]  req;
        logic        vld;
        logic [7:0]  e_out;
        logic        e_ovld;
        logic        e_rdy;
        logic [1:0]  e_cur;
        logic        e_err;
    } vec_t;

    localparam logic [31:0] D0 = 32'hF03C11A5;  // ch0=A5 ch1=11 ch2=3C ch3=F0
    localparam logic [31:0] D1 = 32'hF03C77A5;  // only ch1 changed

    vec_t tv[25];
    logic [7:0] dat[4];
    logic [7:0] dat_prev_a;
    logic [1:0] c_cur_m;

    initial begin
        // Each row gives the inputs for one edge and the outputs expected
        // just after that edge.
        //          rst   din  req   vld   out    ovld  rdy   cur   err
        tv[0]  = '{1'b1, D0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0};
        tv[1]  = '{1'b1, D0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0};
        tv[2]  = '{1'b0, D0, 2'd0, 1'b0, 8'hA5, 1'b1, 1'b1, 2'd0, 1'b0};
        tv[3]  = '{1'b0, D1, 2'd0, 1'b0, 8'hA5, 1'b1, 1'b1, 2'd0, 1'b0};
        // Switch 0 -> 2.
        tv[4]  = '{1'b0, D0, 2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[5]  = '{1'b0, D0, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[6]  = '{1'b0, D0, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0};
        tv[7]  = '{1'b0, D0, 2'd2, 1'b0, 8'h3C, 1'b1, 1'b1, 2'd2, 1'b0};
        // Request for the current channel: no blanking.
        tv[8]  = '{1'b0, D0, 2'd2, 1'b1, 8'h3C, 1'b1, 1'b1, 2'd2, 1'b0};
        tv[9]  = '{1'b0, D0, 2'd2, 1'b0, 8'h3C, 1'b1, 1'b1, 2'd2, 1'b0};
        // Switch 2 -> 1. A request for ch3 is held through the blanking and
        // is taken only once READY returns.
        tv[10] = '{1'b0, D0, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0};
        tv[11] = '{1'b0, D0, 2'd3, 1'b1, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0};
        tv[12] = '{1'b0, D0, 2'd3, 1'b1, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0};
        tv[13] = '{1'b0, D0, 2'd3, 1'b1, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0};
        tv[14] = '{1'b0, D0, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0};
        tv[15] = '{1'b0, D0, 2'd3, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b0};
        tv[16] = '{1'b0, D0, 2'd3, 1'b0, 8'hF0, 1'b1, 1'b1, 2'd3, 1'b0};
        // Return to 0.
        tv[17] = '{1'b0, D0, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd3, 1'b0};
        tv[18] = '{1'b0, D0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b0};
        tv[19] = '{1'b0, D0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0};
        tv[20] = '{1'b0, D0, 2'd0, 1'b0, 8'hA5, 1'b1, 1'b1, 2'd0, 1'b0};
        // Start 0 -> 3, then assert RST in the first BREAK cycle.
        tv[21] = '{1'b0, D0, 2'd3, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[22] = '{1'b1, D0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0};
        tv[23] = '{1'b0, D0, 2'd0, 1'b0, 8'hA5, 1'b1, 1'b1, 2'd0, 1'b0};
        tv[24] = '{1'b0, D0, 2'd0, 1'b0, 8'hA5, 1'b1, 1'b1, 2'd0, 1'b0};

        a_in = D0; a_req = 2'd0; a_vld = 1'b0;
        b_in = 24'h563412; b_req = 2'd0; b_vld = 1'b0;
        c_in = 32'h0; c_req = 2'd0; c_vld = 1'b0;

        // ---------------- table for instance A ----------------
        for (int i = 0; i < 25; i++) begin
            rst   = tv[i].rst;
            a_in  = tv[i].din;
            a_req = tv[i].req;
            a_vld = tv[i].vld;
            step();
            chk($sformatf("A v%0d OUT", i),       32'(a_out),  32'(tv[i].e_out));
            chk($sformatf("A v%0d OUT_VALID", i), 32'(a_ovld), 32'(tv[i].e_ovld));
            chk($sformatf("A v%0d SEL_READY", i), 32'(a_rdy),  32'(tv[i].e_rdy));
            chk($sformatf("A v%0d CUR_SEL", i),   32'(a_cur),  32'(tv[i].e_cur));
            chk($sformatf("A v%0d SEL_ERR", i),   32'(a_err),  32'(tv[i].e_err));
        end
        a_vld = 1'b0;

        // ---------------- instance B: out-of-range request ----------------
        chk("B idle OUT", 32'(b_out), 32'h12);
        b_req = 2'd3; b_vld = 1'b1;
        step();
        chk("B rej SEL_ERR",   32'(b_err),  32'h1);
        chk("B rej CUR_SEL",   32'(b_cur),  32'h0);
        chk("B rej OUT",       32'(b_out),  32'h12);
        chk("B rej OUT_VALID", 32'(b_ovld), 32'h1);
        chk("B rej SEL_READY", 32'(b_rdy),  32'h1);
        b_vld = 1'b0;
        step();
        chk("B after SEL_ERR",   32'(b_err),  32'h0);
        chk("B after OUT",       32'(b_out),  32'h12);
        chk("B after OUT_VALID", 32'(b_ovld), 32'h1);
        // An in-range request must not raise SEL_ERR.
        b_req = 2'd2; b_vld = 1'b1;
        step();
        chk("B inrange SEL_ERR",   32'(b_err), 32'h0);
        chk("B inrange SEL_READY", 32'(b_rdy), 32'h0);
        b_vld = 1'b0;

        // ---------------- instance C: no-dead-time pair sweep ----------------
        c_cur_m = 2'd0;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < 4; k++) dat[k] = 8'($urandom);
                c_in  = {dat[3], dat[2], dat[1], dat[0]};
                c_req = 2'(a); c_vld = 1'b1;
                step();
                // The output at the accept edge still comes from the old channel.
                chk($sformatf("C %0d%0d accA OUT", a, b),   32'(c_out),  32'(dat[c_cur_m]));
                chk($sformatf("C %0d%0d accA CUR", a, b),   32'(c_cur),  32'(a));
                chk($sformatf("C %0d%0d accA VALID", a, b), 32'(c_ovld), 32'h1);
                chk($sformatf("C %0d%0d accA READY", a, b), 32'(c_rdy),  32'h1);
                c_cur_m = 2'(a);
                for (int k = 0; k < 4; k++) dat[k] = 8'($urandom);
                c_in  = {dat[3], dat[2], dat[1], dat[0]};
                dat_prev_a = dat[a];
                c_req = 2'(b);
                step();
                chk($sformatf("C %0d%0d accB OUT", a, b),   32'(c_out),  32'(dat_prev_a));
                chk($sformatf("C %0d%0d accB CUR", a, b),   32'(c_cur),  32'(b));
                chk($sformatf("C %0d%0d accB VALID", a, b), 32'(c_ovld), 32'h1);
                chk($sformatf("C %0d%0d accB READY", a, b), 32'(c_rdy),  32'h1);
                c_cur_m = 2'(b);
                c_vld = 1'b0;
                step();
                chk($sformatf("C %0d%0d new OUT", a, b),   32'(c_out),  32'(dat[b]));
                chk($sformatf("C %0d%0d new VALID", a, b), 32'(c_ovld), 32'h1);
                chk($sformatf("C %0d%0d new ERR", a, b),   32'(c_err),  32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signal_switch_nto1.md
Name: signal_switch_nto1

Overview:
Parametrised N-to-1 registered digital signal switch. It is the successor of the 2-to-1 mux and extends it in three ways: a configurable channel count and data width, a valid/ready select handshake, and a break-before-make dead time on every channel change. It sits between the channel input sources and downstream consumers. A consumer never sees a mixed-source word, because the output is forced to zero and flagged invalid while the switch moves between channels.

Parameters:
N_CH, 4, number of input channels; N_CH >= 2, need not be a power of 2.
WIDTH, 8, data bits per channel.
DEAD_CYCLES, 2, number of cycles the output is blanked on a channel change; 0 means switch immediately with no blanking.
RST_CH, 0, channel selected after reset; RST_CH < N_CH.
SEL_W, derived as max(1, clog2(N_CH)), width of the select bus; not overridable.

Ports:
CLK  in  1  single clock; all logic on the rising edge.
RST  in  1  synchronous, active-high reset.
IN_DATA  in  N_CH*WIDTH  packed channels; channel k is IN_DATA[k*WIDTH +: WIDTH].
SEL_REQ  in  SEL_W  requested channel.
SEL_VALID  in  1  select request valid.
SEL_READY  out  1  switch can accept a request.
OUT  out  WIDTH  registered output data.
OUT_VALID  out  1  OUT carries the current channel's data.
CUR_SEL  out  SEL_W  channel currently connected.
SEL_ERR  out  1  one-cycle pulse when an out-of-range request is rejected.

Behaviour:
- One clock (CLK). RST is synchronous and active-high, and it has priority over every other event in the same cycle.
- Reset values:
  - OUT=0, OUT_VALID=0, SEL_ERR=0.
  - CUR_SEL=RST_CH.
  - State=ACTIVE, so SEL_READY=1.
  - Any pending request and the dead-time counter are cleared.
- States: ACTIVE and BREAK. SEL_READY is a combinational decode of state==ACTIVE.
- ACTIVE, each edge:
  - OUT <= channel CUR_SEL of IN_DATA, OUT_VALID <= 1.
  - Latency is 1 cycle from IN_DATA to OUT.
  - OUT_VALID first rises on the second edge after RST deasserts.
- A request is accepted on an edge where SEL_VALID && SEL_READY.
  - SEL_REQ >= N_CH: rejected. SEL_ERR=1 for exactly the next cycle. CUR_SEL and the output path are unchanged, with no gap.
  - SEL_REQ == CUR_SEL: accepted as a no-op. No blanking and no SEL_ERR.
  - Otherwise, with DEAD_CYCLES > 0:
    - At the accept edge, latch PEND_SEL and enter BREAK with counter = DEAD_CYCLES-1.
    - OUT <= 0 and OUT_VALID <= 0 at that edge and at every BREAK edge.
    - When the counter reaches 0, at that edge: CUR_SEL <= PEND_SEL and state <= ACTIVE.
    - Net effect: OUT=0, OUT_VALID=0 and SEL_READY=0 for exactly DEAD_CYCLES cycles after the accept edge. The new channel's data appears on OUT one cycle later.
  - Otherwise, with DEAD_CYCLES == 0: CUR_SEL <= SEL_REQ at the accept edge. OUT carries the new channel from the next edge, OUT_VALID never drops, and SEL_READY stays 1.
- In BREAK, SEL_VALID is ignored and nothing is queued. The requester holds SEL_VALID/SEL_REQ until it sees SEL_READY.
- Back-to-back requests:
  - With DEAD_CYCLES == 0, one request is accepted per cycle.
  - Otherwise the next request is accepted on the first ACTIVE edge.
- IN_DATA changes on non-selected channels have no effect on any output.
- RST during BREAK: the pending switch is dropped and the block follows the reset values above (CUR_SEL=RST_CH).
- Width rules:
  - When N_CH is not a power of 2, codes N_CH..2^SEL_W-1 are out of range and trigger SEL_ERR.
  - When N_CH is a power of 2, SEL_ERR never fires.

Test Plan:
1. Reset and pass-through (N_CH=4, WIDTH=8, DEAD_CYCLES=2, channels {0xA5, 0x11, 0x3C, 0xF0}): release RST -> CUR_SEL=0, SEL_READY=1, OUT=0xA5 with OUT_VALID=1 from the second edge. Change ch1 only -> OUT holds 0xA5.
2. Switch 0 -> 2: SEL_REQ=2 with SEL_VALID for 1 cycle -> OUT=0x00, OUT_VALID=0, SEL_READY=0 for exactly 2 cycles, then OUT=0x3C, CUR_SEL=2, OUT_VALID=1. A SEL_VALID held during the blanking window is accepted only once READY returns.
3. Same-select request SEL_REQ=2 while CUR_SEL=2 -> no blanking: OUT_VALID stays 1, OUT stays 0x3C, SEL_ERR=0.
4. N_CH=3 instance, SEL_REQ=3 -> SEL_ERR=1 for exactly one cycle; CUR_SEL and OUT unchanged, OUT_VALID stays 1.
5. Assert RST on the 1st BREAK cycle of a 0 -> 3 switch -> after reset CUR_SEL=0, and OUT=0xA5 after the second edge with OUT_VALID=1; channel 3 is never output.
6. DEAD_CYCLES=0 instance: sweep every (current, requested) channel pair with random data -> OUT equals the new channel one edge after accept, OUT_VALID constant 1, SEL_READY constant 1.
